ppl_trace_monitor: RTL and testbench

Synthesisable run monitor for the pipelined MIPS core: captures result words from up to CHANNELS pipeline tap points during a bounded run window, buffers them in a readable FIFO, and compresses them into a MISR signature. It sits beside `Main`, sharing its clock and reset, and replaces hand-inspected waveforms with a checkable signature, a cycle count and a drainable trace.

---
 rtl/ppl_trace_monitor.sv | 276 +++++++++++++++++++++++++++
 tb/tb_ppl_trace_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppl_trace_monitor.sv
// ppl_trace_monitor: bounded-window run monitor for the pipelined MIPS core.
// Captures words from up to CHANNELS tap points into per-channel holding
// registers. A round-robin arbiter moves them into a readable trace FIFO, and
// each push is folded into a MISR signature.
// Build option: define TRACE_MON_SIG_EN to compile the MISR in. Without it,
// signature_o is tied to zero.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset; waiting for start
// S_RUN   | taps captured, cycle counter running, run budget counting down
// S_DRAIN | taps ignored; holding registers still being pushed to the FIFO
// S_DONE  | all captured words are in the FIFO; start begins a fresh run

module ppl_trace_monitor #(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       CHANNELS   = 2,
    parameter int unsigned       DEPTH      = 16,
    parameter int unsigned       RUN_CYCLES = 1024,
    parameter logic [DATA_W-1:0] POLY       = 32'h04C11DB7
) (
    input  logic                       clk_sys_i,
    input  logic                       rst_b_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [CHANNELS-1:0]        tap_valid_i,
    input  logic [CHANNELS*DATA_W-1:0] tap_data_i,
    input  logic                       rd_en_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic [1:0]                 rd_chan_o,
    output logic                       fifo_empty_o,
    output logic                       fifo_full_o,
    output logic                       overflow_o,
    output logic [DATA_W-1:0]          signature_o,
    output logic [31:0]                cycle_count_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [31:0] BUDGET_INIT = 32'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   clr_run;
    logic   in_run;

    logic [31:0] budget_q, budget_d;
    logic        budget_tc;
    logic [31:0] cycle_count_q, cycle_count_d;

    logic [CHANNELS-1:0] hold_vld_q, hold_vld_d;
    logic [DATA_W-1:0]   hold_data_q [CHANNELS];
    logic [DATA_W-1:0]   hold_data_d [CHANNELS];
    logic                overflow_q, overflow_d;

    logic [CW-1:0]       rr_q, rr_d;
    logic                gnt_vld;
    logic [CW-1:0]       gnt_idx;
    logic [CHANNELS-1:0] gnt_vec;
    logic [DATA_W-1:0]   gnt_data;
    int                  cand;

    logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_data_q [DEPTH];
    logic [1:0]        mem_chan_q [DEPTH];
    logic              push, pop, push_ok;

    assign in_run    = (state_q == S_RUN);
    assign budget_tc = (budget_q == '0);

    // Next-state decode; a start accepted from IDLE or DONE clears the run context.
    always_comb begin
        state_d = state_q;
        clr_run = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    clr_run = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_i || budget_tc) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (hold_vld_q == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    clr_run = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Run budget down-counter (terminal count ends RUN) and saturating cycle counter.
    always_comb begin
        budget_d      = budget_q;
        cycle_count_d = cycle_count_q;
        if (clr_run) begin
            budget_d      = BUDGET_INIT;
            cycle_count_d = '0;
        end else if (in_run) begin
            if (!budget_tc)            budget_d      = budget_q - 32'd1;
            if (cycle_count_q != '1)   cycle_count_d = cycle_count_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            budget_q      <= '0;
            cycle_count_q <= '0;
        end else begin
            budget_q      <= budget_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    // FIFO status; a pop frees a slot for a push in the same cycle.
    assign fifo_empty_o = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop          = rd_en_i && !fifo_empty_o;
    assign push_ok      = !fifo_full_o || pop;

    // Round-robin grant: search from rr_q for the first occupied holding register.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        cand    = 0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            cand = (int'(rr_q) + k) % int'(CHANNELS);
            if (!gnt_vld && push_ok && hold_vld_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(cand);
            end
        end
        if (gnt_vld) gnt_vec[gnt_idx] = 1'b1;
    end

    assign gnt_data = hold_data_q[gnt_idx];
    assign push     = gnt_vld;

    // Search pointer moves to the channel after the one just granted.
    always_comb begin
        rr_d = rr_q;
        if (clr_run) begin
            rr_d = '0;
        end else if (gnt_vld) begin
            rr_d = (int'(gnt_idx) == int'(CHANNELS) - 1) ? '0 : gnt_idx + CW'(1);
        end
    end

    // Holding registers: a tap loads only into an empty or departing slot, else it is dropped.
    always_comb begin
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        overflow_d  = overflow_q;
        if (clr_run) begin
            hold_vld_d = '0;
            overflow_d = 1'b0;
        end else begin
            for (int c = 0; c < int'(CHANNELS); c++) begin
                if (gnt_vec[c]) hold_vld_d[c] = 1'b0;
                if (in_run && tap_valid_i[c]) begin
                    if (!hold_vld_q[c] || gnt_vec[c]) begin
                        hold_vld_d[c]  = 1'b1;
                        hold_data_d[c] = tap_data_i[c*DATA_W +: DATA_W];
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
        end
    end

    // Holding register, overflow flag and arbiter pointer storage.
    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            hold_vld_q <= '0;
            overflow_q <= 1'b0;
            rr_q       <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) hold_data_q[c] <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            overflow_q  <= overflow_d;
            rr_q        <= rr_d;
            hold_data_q <= hold_data_d;
        end
    end

    // FIFO pointer update; a new run discards whatever trace was left.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_run) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge clk_sys_i) begin
        if (push) begin
            mem_data_q[wr_ptr_q[AW-1:0]] <= gnt_data;
            mem_chan_q[wr_ptr_q[AW-1:0]] <= 2'(gnt_idx);
        end
    end

    // Head is forced to zero while empty so stale storage never shows.
    assign rd_data_o = fifo_empty_o ? '0 : mem_data_q[rd_ptr_q[AW-1:0]];
    assign rd_chan_o = fifo_empty_o ? '0 : mem_chan_q[rd_ptr_q[AW-1:0]];

`ifdef TRACE_MON_SIG_EN
    logic [DATA_W-1:0] sig_q, sig_d;

    // MISR folds every word pushed into the FIFO.
    always_comb begin
        sig_d = sig_q;
        if (clr_run) begin
            sig_d = '0;
        end else if (push) begin
            sig_d = {sig_q[DATA_W-2:0], 1'b0} ^ (sig_q[DATA_W-1] ? POLY : '0) ^ gnt_data;
        end
    end

    // Signature register.
    always_ff @(posedge clk_sys_i or negedge rst_b_i) begin
        if (!rst_b_i) sig_q <= '0;
        else          sig_q <= sig_d;
    end

    assign signature_o = sig_q;
`else
    // MISR compiled out: signature reads as zero, polynomial left referenced.
    assign signature_o = POLY & {DATA_W{1'b0}};
`endif

    assign overflow_o    = overflow_q;
    assign cycle_count_o = cycle_count_q;
    assign busy_o        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o        = (state_q == S_DONE);

endmodule

// File: tb/tb_ppl_trace_monitor.sv
// Directed bench for ppl_trace_monitor: a default-size instance plus a
// RUN_CYCLES=8 instance for the forced-stop boundary.
module tb_ppl_trace_monitor;

    logic        clk_sys = 1'b0;
    logic        rst_b;
    logic        start, stop, rd_en;
    logic [1:0]  tap_valid;
    logic [63:0] tap_data;
    logic [31:0] rd_data, signature, cycle_count;
    logic [1:0]  rd_chan;
    logic        fifo_empty, fifo_full, overflow, busy, done;

    logic        start8;
    logic [31:0] rd_data8, signature8, cycle_count8;
    logic [1:0]  rd_chan8;
    logic        fifo_empty8, fifo_full8, overflow8, busy8, done8;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] sig_m;
    logic [31:0] sig_first;
    logic [31:0] exp_d [18];
    logic [1:0]  exp_c [18];

    always #5 clk_sys = ~clk_sys;

    ppl_trace_monitor u_dut (
        .clk_sys_i     (clk_sys),
        .rst_b_i       (rst_b),
        .start_i       (start),
        .stop_i        (stop),
        .tap_valid_i   (tap_valid),
        .tap_data_i    (tap_data),
        .rd_en_i       (rd_en),
        .rd_data_o     (rd_data),
        .rd_chan_o     (rd_chan),
        .fifo_empty_o  (fifo_empty),
        .fifo_full_o   (fifo_full),
        .overflow_o    (overflow),
        .signature_o   (signature),
        .cycle_count_o (cycle_count),
        .busy_o        (busy),
        .done_o        (done)
    );

    ppl_trace_monitor #(.RUN_CYCLES(8)) u_dut8 (
        .clk_sys_i     (clk_sys),
        .rst_b_i       (rst_b),
        .start_i       (start8),
        .stop_i        (1'b0),
        .tap_valid_i   (2'b00),
        .tap_data_i    (64'h0),
        .rd_en_i       (1'b0),
        .rd_data_o     (rd_data8),
        .rd_chan_o     (rd_chan8),
        .fifo_empty_o  (fifo_empty8),
        .fifo_full_o   (fifo_full8),
        .overflow_o    (overflow8),
        .signature_o   (signature8),
        .cycle_count_o (cycle_count8),
        .busy_o        (busy8),
        .done_o        (done8)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ d;
    endfunction

    function automatic logic [31:0] sig_exp(input logic [31:0] m);
`ifdef TRACE_MON_SIG_EN
        return m;
`else
        return 32'h0 & m;
`endif
    endfunction

    task automatic wait_done(input string tag, input int bound);
        int n = 0;
        while (!done && n < bound) begin
            @(negedge clk_sys);
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    // tap0 carries 1,2,3; stop ends the run (optionally with a competing start).
    task automatic run_small(input string tag, input logic start_with_stop);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_done_low"}, done, 1'b0);
        chk({tag, "_cnt_clr"}, cycle_count, 32'd0);
        tap_valid = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            tap_data = 64'(i);
            @(negedge clk_sys);
        end
        tap_valid = 2'b00;
        tap_data  = '0;
        stop      = 1'b1;
        start     = start_with_stop;
        @(negedge clk_sys);
        stop  = 1'b0;
        start = 1'b0;
        wait_done({tag, "_done"}, 20);
        chk({tag, "_cycles"}, cycle_count, 32'd4);
        chk({tag, "_ovf"}, overflow, 1'b0);
        sig_m = 32'h0;
        for (int i = 1; i <= 3; i++) sig_m = misr_step(sig_m, 32'(i));
        chk({tag, "_sig"}, signature, sig_exp(sig_m));
        for (int i = 1; i <= 3; i++) begin
            chk({tag, "_nonempty"}, fifo_empty, 1'b0);
            chk({tag, "_rd_data"}, rd_data, 64'(i));
            chk({tag, "_rd_chan"}, rd_chan, 2'd0);
            rd_en = 1'b1;
            @(negedge clk_sys);
            rd_en = 1'b0;
        end
        chk({tag, "_empty"}, fifo_empty, 1'b1);
        rd_en = 1'b1;
        @(negedge clk_sys);
        rd_en = 1'b0;
        chk({tag, "_empty_pop_ignored"}, fifo_empty, 1'b1);
        chk({tag, "_empty_pop_full"}, fifo_full, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_b     = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        rd_en     = 1'b0;
        tap_valid = 2'b00;
        tap_data  = '0;
        start8    = 1'b0;
        repeat (3) @(negedge clk_sys);
        rst_b = 1'b1;
        @(negedge clk_sys);

        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_rd_chan", rd_chan, 2'd0);
        chk("rst_empty", fifo_empty, 1'b1);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_sig", signature, 32'h0);
        chk("rst_cycles", cycle_count, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy8", busy8, 1'b0);

        // Simple run from IDLE.
        run_small("small1", 1'b0);
        sig_first = signature;

        // Both taps every cycle for 20 cycles, no pops: fill, backpressure, drops.
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        chk("fill_busy", busy, 1'b1);
        tap_valid = 2'b11;
        for (int i = 0; i < 20; i++) begin
            tap_data = {32'h200 + 32'(i), 32'h100 + 32'(i)};
            @(negedge clk_sys);
        end
        tap_valid = 2'b00;
        tap_data  = '0;
        chk("fill_full", fifo_full, 1'b1);
        chk("fill_ovf", overflow, 1'b1);
        chk("fill_sig_restart", signature !== sig_exp(32'h3) || sig_exp(32'h3) == 32'h0, 1'b1);
        stop = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0;
        chk("fill_cycles", cycle_count, 32'd21);
        chk("fill_drain_busy", busy, 1'b1);
        chk("fill_drain_not_done", done, 1'b0);

        exp_d[0] = 32'h100; exp_c[0] = 2'd0;
        exp_d[1] = 32'h200; exp_c[1] = 2'd1;
        for (int k = 2; k < 16; k++) begin
            exp_d[k] = (k % 2 == 0) ? 32'h100 + 32'(k - 1) : 32'h200 + 32'(k - 1);
            exp_c[k] = (k % 2 == 0) ? 2'd0 : 2'd1;
        end
        exp_d[16] = 32'h10F; exp_c[16] = 2'd0;
        exp_d[17] = 32'h210; exp_c[17] = 2'd1;

        sig_m = 32'h0;
        for (int k = 0; k < 18; k++) begin
            chk($sformatf("fill_pop%0d_data", k), rd_data, exp_d[k]);
            chk($sformatf("fill_pop%0d_chan", k), rd_chan, exp_c[k]);
            sig_m = misr_step(sig_m, exp_d[k]);
            rd_en = 1'b1;
            @(negedge clk_sys);
        end
        rd_en = 1'b0;
        chk("fill_empty_after", fifo_empty, 1'b1);
        wait_done("fill_done", 20);
        chk("fill_sig", signature, sig_exp(sig_m));

        // Restart from DONE; stop wins over a simultaneous start in RUN.
        run_small("small2", 1'b1);
        chk("restart_sig_repeat", signature, sig_first);

        // Asynchronous reset mid-run with five entries queued.
        start = 1'b1;
        @(negedge clk_sys);
        start     = 1'b0;
        tap_valid = 2'b01;
        for (int i = 0; i < 5; i++) begin
            tap_data = 64'(32'h11 + 32'(i));
            @(negedge clk_sys);
        end
        tap_valid = 2'b00;
        tap_data  = '0;
        @(negedge clk_sys);
        chk("mid_head", rd_data, 32'h11);
        chk("mid_busy", busy, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        chk("arst_empty", fifo_empty, 1'b1);
        chk("arst_sig", signature, 32'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_cycles", cycle_count, 32'h0);
        chk("arst_rd_data", rd_data, 32'h0);
        @(negedge clk_sys);
        rst_b = 1'b1;
        @(negedge clk_sys);
        chk("post_rst_idle", {busy, done}, 2'b00);

        // Forced stop at RUN_CYCLES=8 on the second instance.
        start8 = 1'b1;
        @(negedge clk_sys);
        start8 = 1'b0;
        chk("rc8_busy", busy8, 1'b1);
        repeat (7) @(negedge clk_sys);
        chk("rc8_still_busy", busy8, 1'b1);
        chk("rc8_cycles7", cycle_count8, 32'd7);
        begin
            int n = 0;
            while (!done8 && n < 30) begin
                @(negedge clk_sys);
                n++;
            end
        end
        chk("rc8_done", done8, 1'b1);
        chk("rc8_cycles", cycle_count8, 32'd8);
        chk("rc8_main_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
